// File: rtl/data_memory_pkg.sv
// Shared definitions for the data memory responder: FSM states, word geometry
// and the width of the response-latency counter.
package data_memory_pkg;

    localparam int WORD_BYTES  = 8;
    localparam int WORD_BITS   = 64;
    localparam int OFFSET_BITS = $clog2(WORD_BYTES);
    localparam int CNT_WIDTH   = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        RESPOND = 2'd2
    } state_e;

endpackage

// File: rtl/data_memory_responder_wait_counter.sv
// Loadable down-counter that times the gap between accepting a request and
// presenting its response. zero reports the count as it will be after this edge.
module wait_counter
    import data_memory_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 load,
    input  logic [CNT_WIDTH-1:0] load_value,
    input  logic                 decrement,
    output logic                 zero
);

    logic [CNT_WIDTH-1:0] count_q;
    logic [CNT_WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (decrement && (count_q != '0)) begin
            count_d = count_q - CNT_WIDTH'(1);
        end
    end

    // Looking at the next value lets the FSM leave WAIT on the 1->0 edge itself.
    assign zero = (count_d == '0);

    // NOTE: state registers use non-blocking assignments only; all next-state
    // arithmetic lives in the always_comb above.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/data_memory_responder.sv
// Single-port doubleword data memory behind a valid/ready request/response
// handshake with a fixed LATENCY. Define DATA_MEMORY_ALIGN_CHECK_EN to reject
// addresses that are not doubleword aligned.
module data_memory_responder
    import data_memory_pkg::*;
#(
    parameter int DEPTH_WORDS = 128,
    parameter int LATENCY     = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        request_valid,
    input  logic        request_write,
    input  logic [63:0] request_address,
    input  logic [63:0] request_data,
    output logic        request_ready,
    output logic        response_valid,
    input  logic        response_ready,
    output logic [63:0] response_data,
    output logic        response_error
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int HI_W  = WORD_BITS - OFFSET_BITS;

    logic [WORD_BITS-1:0] mem [DEPTH_WORDS];

    state_e               state_q, state_d;
    logic                 request_ready_q, request_ready_d;
    logic                 response_valid_q, response_valid_d;
    logic [WORD_BITS-1:0] response_data_q, response_data_d;
    logic                 response_error_q, response_error_d;
    logic                 write_q, write_d;
    logic [IDX_W-1:0]     index_q, index_d;
    logic [WORD_BITS-1:0] data_q, data_d;
    logic                 error_q, error_d;

    logic accept;
    logic commit;
    logic mem_we;
    logic cnt_zero;
    logic request_error;

    assign accept = request_valid && request_ready_q;

    // Out-of-range check uses the full upper address so aliasing cannot hide an error.
    always_comb begin
        request_error = (request_address[WORD_BITS-1:OFFSET_BITS] >= HI_W'(DEPTH_WORDS));
`ifdef DATA_MEMORY_ALIGN_CHECK_EN
        request_error = request_error || (request_address[OFFSET_BITS-1:0] != '0);
`endif
    end

`ifndef DATA_MEMORY_ALIGN_CHECK_EN
    logic unused_offset_bits;
    assign unused_offset_bits = ^request_address[OFFSET_BITS-1:0];
`endif

    wait_counter u_wait_counter (
        .clock      (clock),
        .reset      (reset),
        .load       (accept),
        .load_value (CNT_WIDTH'(LATENCY)),
        .decrement  (state_q == WAIT),
        .zero       (cnt_zero)
    );

    always_comb begin
        state_d          = state_q;
        write_d          = write_q;
        index_d          = index_q;
        data_d           = data_q;
        error_d          = error_q;
        response_data_d  = response_data_q;
        response_error_d = response_error_q;

        // With LATENCY=0 the commit happens on the accept edge, so the captured
        // fields are forwarded straight from the request inputs.
        if (accept) begin
            write_d = request_write;
            index_d = request_address[OFFSET_BITS +: IDX_W];
            data_d  = request_data;
            error_d = request_error;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = cnt_zero ? RESPOND : WAIT;
                end
            end
            WAIT: begin
                if (cnt_zero) begin
                    state_d = RESPOND;
                end
            end
            RESPOND: begin
                if (response_ready) begin
                    state_d          = IDLE;
                    response_data_d  = '0;
                    response_error_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        commit = (state_d == RESPOND) && (state_q != RESPOND);
        if (commit) begin
            response_error_d = error_d;
            response_data_d  = (write_d || error_d) ? '0 : mem[index_d];
        end

        mem_we           = commit && write_d && !error_d && !reset;
        response_valid_d = (state_d == RESPOND);
        request_ready_d  = (state_d == IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q          <= IDLE;
            request_ready_q  <= 1'b1;
            response_valid_q <= 1'b0;
            response_data_q  <= '0;
            response_error_q <= 1'b0;
            write_q          <= 1'b0;
            index_q          <= '0;
            data_q           <= '0;
            error_q          <= 1'b0;
        end else begin
            state_q          <= state_d;
            request_ready_q  <= request_ready_d;
            response_valid_q <= response_valid_d;
            response_data_q  <= response_data_d;
            response_error_q <= response_error_d;
            write_q          <= write_d;
            index_q          <= index_d;
            data_q           <= data_d;
            error_q          <= error_d;
        end
    end

    // NOTE: the storage array is deliberately left out of reset: contents must
    // survive a reset, and a reset term would prevent RAM inference.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[index_d] <= data_d;
        end
    end

    assign request_ready  = request_ready_q;
    assign response_valid = response_valid_q;
    assign response_data  = response_data_q;
    assign response_error = response_error_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder: one instance at LATENCY=2 and one
// at LATENCY=0 with response_ready tied high.
module tb_data_memory_responder;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic        rv2 = 1'b0, rw2 = 1'b0, rs_ready2 = 1'b0;
    logic [63:0] ra2 = '0, rd2 = '0;
    logic        rq_ready2, rs_valid2, rs_err2;
    logic [63:0] rs_data2;

    logic        rv0 = 1'b0, rw0 = 1'b0, rs_ready0 = 1'b1;
    logic [63:0] ra0 = '0, rd0 = '0;
    logic        rq_ready0, rs_valid0, rs_err0;
    logic [63:0] rs_data0;

    int checks = 0;
    int errors = 0;

    logic [63:0] v10;
    int          seen;

    logic        t_wr   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [63:0] t_data [4] = '{64'hA5A5_0000_1111_2222, 64'h0, 64'h0123_4567_89AB_CDEF, 64'h0};
    logic [63:0] t_exp  [4] = '{64'h0, 64'hA5A5_0000_1111_2222, 64'h0, 64'h0123_4567_89AB_CDEF};

    data_memory_responder #(.DEPTH_WORDS(128), .LATENCY(2)) u_dut2 (
        .clock           (clock),
        .reset           (reset),
        .request_valid   (rv2),
        .request_write   (rw2),
        .request_address (ra2),
        .request_data    (rd2),
        .request_ready   (rq_ready2),
        .response_valid  (rs_valid2),
        .response_ready  (rs_ready2),
        .response_data   (rs_data2),
        .response_error  (rs_err2)
    );

    data_memory_responder #(.DEPTH_WORDS(128), .LATENCY(0)) u_dut0 (
        .clock           (clock),
        .reset           (reset),
        .request_valid   (rv0),
        .request_write   (rw0),
        .request_address (ra0),
        .request_data    (rd0),
        .request_ready   (rq_ready0),
        .response_valid  (rs_valid0),
        .response_ready  (rs_ready0),
        .response_data   (rs_data0),
        .response_error  (rs_err0)
    );

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One LATENCY=2 transaction; hold>0 keeps response_ready low that many
    // cycles while a conflicting store to 0x10 is offered.
    task automatic txn2(input logic wr, input logic [63:0] addr, input logic [63:0] wdata,
                        input logic [63:0] exp_data, input logic exp_err, input int hold,
                        input string tag);
        int n;
        @(negedge clock);
        rv2 = 1'b1; rw2 = wr; ra2 = addr; rd2 = wdata;
        n = 0;
        while (!rq_ready2 && n < 20) begin
            @(negedge clock);
            n++;
        end
        check({tag, "_req_ready"}, 64'(rq_ready2), 64'd1);
        @(negedge clock);
        rv2 = 1'b0; rw2 = ~wr; ra2 = {$urandom, $urandom}; rd2 = {$urandom, $urandom};
        check({tag, "_busy"}, 64'(rq_ready2), 64'd0);
        n = 1;
        while (!rs_valid2 && n < 20) begin
            @(negedge clock);
            n++;
        end
        check({tag, "_latency"}, 64'(n), 64'd3);
        check({tag, "_data"}, rs_data2, exp_data);
        check({tag, "_err"}, 64'(rs_err2), 64'(exp_err));
        for (int i = 0; i < hold; i++) begin
            rv2 = 1'b1; rw2 = 1'b1; ra2 = 64'h10; rd2 = 64'hBAD;
            @(negedge clock);
            check({tag, "_hold_valid"}, 64'(rs_valid2), 64'd1);
            check({tag, "_hold_data"}, rs_data2, exp_data);
            check({tag, "_hold_ready"}, 64'(rq_ready2), 64'd0);
        end
        rv2 = 1'b0;
        rs_ready2 = 1'b1;
        @(negedge clock);
        rs_ready2 = 1'b0;
        check({tag, "_done_valid"}, 64'(rs_valid2), 64'd0);
        check({tag, "_done_ready"}, 64'(rq_ready2), 64'd1);
    endtask

    initial begin
        repeat (2) @(negedge clock);
        check("rst_ready2", 64'(rq_ready2), 64'd1);
        check("rst_valid2", 64'(rs_valid2), 64'd0);
        check("rst_data2", rs_data2, 64'd0);
        check("rst_err2", 64'(rs_err2), 64'd0);
        check("rst_ready0", 64'(rq_ready0), 64'd1);
        check("rst_valid0", 64'(rs_valid0), 64'd0);
        reset = 1'b0;

        // Store then load at LATENCY=2
        txn2(1'b1, 64'h10, 64'hDEAD_BEEF_0000_0001, 64'h0, 1'b0, 0, "st10");
        txn2(1'b0, 64'h10, 64'h0, 64'hDEAD_BEEF_0000_0001, 1'b0, 0, "ld10");

        // Last valid word, then first out-of-range word
        txn2(1'b1, 64'h3F8, 64'h7777_8888_9999_AAAA, 64'h0, 1'b0, 0, "st3f8");
        txn2(1'b0, 64'h3F8, 64'h0, 64'h7777_8888_9999_AAAA, 1'b0, 0, "ld3f8");
        txn2(1'b0, 64'h400, 64'h0, 64'h0, 1'b1, 0, "ld400");
        txn2(1'b1, 64'h400, 64'h5555, 64'h0, 1'b1, 0, "st400");
        txn2(1'b0, 64'h10, 64'h0, 64'hDEAD_BEEF_0000_0001, 1'b0, 0, "ld10_after_err");
        txn2(1'b0, 64'h3F8, 64'h0, 64'h7777_8888_9999_AAAA, 1'b0, 0, "ld3f8_after_err");

        // Misaligned store
`ifdef DATA_MEMORY_ALIGN_CHECK_EN
        txn2(1'b1, 64'h13, 64'h1111_2222_3333_4444, 64'h0, 1'b1, 0, "st13");
        v10 = 64'hDEAD_BEEF_0000_0001;
`else
        txn2(1'b1, 64'h13, 64'h1111_2222_3333_4444, 64'h0, 1'b0, 0, "st13");
        v10 = 64'h1111_2222_3333_4444;
`endif
        txn2(1'b0, 64'h10, 64'h0, v10, 1'b0, 0, "ld10_after_st13");

        // Stalled response with a competing store offered to 0x10
        txn2(1'b0, 64'h10, 64'h0, v10, 1'b0, 5, "ld10_hold");
        txn2(1'b0, 64'h10, 64'h0, v10, 1'b0, 0, "ld10_after_hold");

        // Reset during WAIT of a store to 0x20
        txn2(1'b1, 64'h20, 64'h0000_2020_0000_2020, 64'h0, 1'b0, 0, "st20_old");
        @(negedge clock);
        rv2 = 1'b1; rw2 = 1'b1; ra2 = 64'h20; rd2 = 64'h9999_9999_9999_9999;
        @(negedge clock);
        rv2 = 1'b0;
        check("wait_ready", 64'(rq_ready2), 64'd0);
        check("wait_valid", 64'(rs_valid2), 64'd0);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("wait_rst_ready", 64'(rq_ready2), 64'd1);
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (rs_valid2) seen++;
        end
        check("wait_rst_no_rsp", 64'(seen), 64'd0);
        txn2(1'b0, 64'h20, 64'h0, 64'h0000_2020_0000_2020, 1'b0, 0, "ld20");

        // Reset during RESPOND of a store: the write stays committed
        @(negedge clock);
        rv2 = 1'b1; rw2 = 1'b1; ra2 = 64'h28; rd2 = 64'h55;
        @(negedge clock);
        rv2 = 1'b0;
        repeat (2) @(negedge clock);
        check("st28_respond", 64'(rs_valid2), 64'd1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("st28_dropped", 64'(rs_valid2), 64'd0);
        txn2(1'b0, 64'h28, 64'h0, 64'h55, 1'b0, 0, "ld28");

        // LATENCY=0, request_valid held high: one accept every 2 cycles
        @(negedge clock);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("l0_%0d_ready", k), 64'(rq_ready0), 64'd1);
            check($sformatf("l0_%0d_idle", k), 64'(rs_valid0), 64'd0);
            rv0 = 1'b1; rw0 = t_wr[k]; ra0 = 64'h08; rd0 = t_data[k];
            @(negedge clock);
            ra0 = {$urandom, $urandom}; rd0 = {$urandom, $urandom}; rw0 = ~t_wr[k];
            check($sformatf("l0_%0d_valid", k), 64'(rs_valid0), 64'd1);
            check($sformatf("l0_%0d_busy", k), 64'(rq_ready0), 64'd0);
            check($sformatf("l0_%0d_data", k), rs_data0, t_exp[k]);
            check($sformatf("l0_%0d_err", k), 64'(rs_err0), 64'd0);
            @(negedge clock);
        end
        rv0 = 1'b0;
        @(negedge clock);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
